sext_narrow_serializer: RTL and testbench

- Transmit side of the team's sign-extension byte-stream link.
- Accepts signed words on a val/rdy input stream and emits them on a val/rdy 8-bit byte stream.
- A word that equals the sign-extension of its low byte goes out as 1 beat; any other word goes out as p_nbytes beats.
- The downstream receiver widens short messages by sign-extending the 8-bit byte to the full word width.

---
 rtl/sext_link_pkg.sv | 15 +
 rtl/sext_narrow_serializer_dpath.sv | 50 +++++
 rtl/sext_narrow_serializer.sv | 86 ++++++++
 tb/tb_sext_narrow_serializer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sext_link_pkg.sv
// Shared types and helpers for the sign-extension byte-stream link.
// Used by the transmit serializer and by the receiver's checker.
package sext_link_pkg;

    localparam int SEXT_LINK_BYTE_W = 8;

    typedef enum logic [1:0] {IDLE, SHORT, LONG} state_t;

    // The caller must sign-extend its word to 64 bits first. The extension bits
    // copy the word's MSB, so testing [63:7] is the same as testing [W-1:7].
    function automatic logic is_sext_short(input logic [63:0] word);
        return (&word[63:7]) | ~(|word[63:7]);
    endfunction

endpackage

// File: rtl/sext_narrow_serializer_dpath.sv
// Datapath for the serializer: the latched word, the beat index k, and the
// little-endian byte select.
module sext_narrow_serializer_dpath
    import sext_link_pkg::*;
#(
    parameter int p_nbytes = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_i,
    input  logic                          adv_i,
    input  logic [8*p_nbytes-1:0]         word_i,
    output logic                          k0_o,
    output logic                          klast_o,
    output logic [SEXT_LINK_BYTE_W-1:0]   byte_o
);
    localparam int W  = 8 * p_nbytes;
    localparam int KW = $clog2(p_nbytes);

    logic [W-1:0]  word_q, word_d;
    logic [KW-1:0] k_q, k_d;

    assign k0_o    = (k_q == '0);
    assign klast_o = (k_q == KW'(p_nbytes - 1));
    assign byte_o  = word_q[{k_q, 3'b000} +: SEXT_LINK_BYTE_W];

    // A load always restarts at beat 0; the final beat wraps k back to 0 so
    // the index is clean for the next word.
    always_comb begin
        word_d = word_q;
        k_d    = k_q;
        if (load_i) begin
            word_d = word_i;
            k_d    = '0;
        end else if (adv_i) begin
            k_d = klast_o ? '0 : k_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            k_q    <= '0;
        end else begin
            word_q <= word_d;
            k_q    <= k_d;
        end
    end

endmodule

// File: rtl/sext_narrow_serializer.sv
// Transmit side of the sign-extension byte-stream link: words that fit in a
// sign-extended byte go out as one beat, all others as p_nbytes beats.
// Optional SEXT_NARROW_SERIALIZER_STATS_EN adds short/long word counters.
module sext_narrow_serializer
    import sext_link_pkg::*;
#(
    parameter int p_nbytes = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_val,
    output logic                        in_rdy,
    input  logic [8*p_nbytes-1:0]       in_msg,
    output logic                        out_val,
    input  logic                        out_rdy,
    output logic [SEXT_LINK_BYTE_W-1:0] out_msg,
    output logic                        out_first,
    output logic                        out_last
`ifdef SEXT_NARROW_SERIALIZER_STATS_EN
    ,
    output logic [31:0]                 num_short,
    output logic [31:0]                 num_long
`endif
);
    state_t state_q, state_d;

    logic                        k0, klast;
    logic [SEXT_LINK_BYTE_W-1:0] dp_byte;
    logic                        xfer_out, accept, in_short;
    logic signed [63:0]          in_ext;

    assign in_ext   = $signed(in_msg);
    assign in_short = is_sext_short(in_ext);

    // All out_* come from registered state only; in_rdy alone looks at out_rdy.
    assign out_val   = (state_q != IDLE);
    assign out_first = (state_q == SHORT) | ((state_q == LONG) & k0);
    assign out_last  = (state_q == SHORT) | ((state_q == LONG) & klast);
    assign out_msg   = out_val ? dp_byte : '0;

    assign xfer_out = out_val & out_rdy;
    assign in_rdy   = (state_q == IDLE) | (out_val & out_last & out_rdy);
    assign accept   = in_val & in_rdy;

    always_comb begin
        state_d = state_q;
        if (accept)
            state_d = in_short ? SHORT : LONG;
        else if (xfer_out & out_last)
            state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    sext_narrow_serializer_dpath #(.p_nbytes(p_nbytes)) u_dpath (
        .clk     (clk),
        .reset   (reset),
        .load_i  (accept),
        .adv_i   (xfer_out & (state_q == LONG)),
        .word_i  (in_msg),
        .k0_o    (k0),
        .klast_o (klast),
        .byte_o  (dp_byte)
    );

`ifdef SEXT_NARROW_SERIALIZER_STATS_EN
    logic [31:0] num_short_q, num_long_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            num_short_q <= '0;
            num_long_q  <= '0;
        end else if (accept) begin
            if (in_short) num_short_q <= num_short_q + 32'd1;
            else          num_long_q  <= num_long_q + 32'd1;
        end
    end

    assign num_short = num_short_q;
    assign num_long  = num_long_q;
`endif

endmodule

// File: tb/tb_sext_narrow_serializer.sv
// Directed bench for sext_narrow_serializer with p_nbytes=4; counter checks
// are compiled in when SEXT_NARROW_SERIALIZER_STATS_EN is defined.
module tb_sext_narrow_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_val;
    logic        in_rdy;
    logic [31:0] in_msg;
    logic        out_val;
    logic        out_rdy;
    logic [7:0]  out_msg;
    logic        out_first;
    logic        out_last;
`ifdef SEXT_NARROW_SERIALIZER_STATS_EN
    logic [31:0] num_short;
    logic [31:0] num_long;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sext_narrow_serializer #(.p_nbytes(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_val    (in_val),
        .in_rdy    (in_rdy),
        .in_msg    (in_msg),
        .out_val   (out_val),
        .out_rdy   (out_rdy),
        .out_msg   (out_msg),
        .out_first (out_first),
        .out_last  (out_last)
`ifdef SEXT_NARROW_SERIALIZER_STATS_EN
        ,
        .num_short (num_short),
        .num_long  (num_long)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic step(input logic v, input logic [31:0] m, input logic r);
        @(negedge clk);
        in_val  = v;
        in_msg  = m;
        out_rdy = r;
        #1;
    endtask

    task automatic beat(input string tag, input logic [7:0] m, input logic f,
                        input logic l, input logic ir);
        chk({tag, ".val"},   32'(out_val),   32'd1);
        chk({tag, ".msg"},   32'(out_msg),   32'(m));
        chk({tag, ".first"}, 32'(out_first), 32'(f));
        chk({tag, ".last"},  32'(out_last),  32'(l));
        chk({tag, ".in_rdy"}, 32'(in_rdy),   32'(ir));
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, ".val"},    32'(out_val), 32'd0);
        chk({tag, ".in_rdy"}, 32'(in_rdy),  32'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset  = 1'b1;
        in_val = 1'b0;
        @(negedge clk);
        #1;
    endtask

    logic [7:0] bp_msg  [7] = '{8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic       bp_rdy  [7] = '{1, 0, 0, 1, 1, 0, 1};
    logic       bp_first[7] = '{1, 0, 0, 0, 0, 0, 0};
    logic       bp_last [7] = '{0, 0, 0, 0, 0, 1, 1};
    logic       bp_inrdy[7] = '{0, 0, 0, 0, 0, 0, 1};

    initial begin
        reset = 1'b1; in_val = 1'b0; in_msg = '0; out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst.val",   32'(out_val),   32'd0);
        chk("rst.first", 32'(out_first), 32'd0);
        chk("rst.last",  32'(out_last),  32'd0);
        chk("rst.msg",   32'(out_msg),   32'd0);
        chk("rst.in_rdy", 32'(in_rdy),   32'd1);
        reset = 1'b0;

        // Short words, one per cycle, no bubbles.
        step(1, 32'h0000_0000, 1); chk("s.rdy0", 32'(in_rdy), 32'd1);
        step(1, 32'h0000_0001, 1); beat("s00", 8'h00, 1, 1, 1);
        step(1, 32'h0000_007F, 1); beat("s01", 8'h01, 1, 1, 1);
        step(1, 32'hFFFF_FF80, 1); beat("s7F", 8'h7F, 1, 1, 1);
        step(1, 32'hFFFF_FFFF, 1); beat("s80", 8'h80, 1, 1, 1);
        step(0, 32'h0, 1);         beat("sFF", 8'hFF, 1, 1, 1);
        step(0, 32'h0, 1);         idle_chk("s.end");

        // Long word, little-endian beats.
        step(1, 32'h1234_5680, 1);
        step(0, 32'h0, 1); beat("l0", 8'h80, 1, 0, 0);
        step(0, 32'h0, 1); beat("l1", 8'h56, 0, 0, 0);
        step(0, 32'h0, 1); beat("l2", 8'h34, 0, 0, 0);
        step(0, 32'h0, 1); beat("l3", 8'h12, 0, 1, 1);
        step(0, 32'h0, 1); idle_chk("l.end");

        // Backpressure on a long boundary word.
        step(1, 32'hFFFF_FF7F, 1);
        for (int i = 0; i < 7; i++) begin
            step(0, 32'h0, bp_rdy[i]);
            beat($sformatf("bp%0d", i), bp_msg[i], bp_first[i], bp_last[i], bp_inrdy[i]);
        end
        step(0, 32'h0, 1); idle_chk("bp.end");

        // Long then short, accepted on the last long beat.
        step(1, 32'h0000_0080, 1);
        step(1, 32'h0000_0055, 1); beat("m0", 8'h80, 1, 0, 0);
        step(1, 32'h0000_0055, 1); beat("m1", 8'h00, 0, 0, 0);
        step(1, 32'h0000_0055, 1); beat("m2", 8'h00, 0, 0, 0);
        step(1, 32'h0000_0055, 1); beat("m3", 8'h00, 0, 1, 1);
        step(0, 32'h0, 1);         beat("m55", 8'h55, 1, 1, 1);
        step(0, 32'h0, 1);         idle_chk("m.end");

        // Reset partway through a long message.
        step(1, 32'hAABB_CCDD, 1);
        step(0, 32'h0, 1); beat("r0", 8'hDD, 1, 0, 0);
        step(0, 32'h0, 1); beat("r1", 8'hCC, 0, 0, 0);
        pulse_reset();
        idle_chk("r.rst");
        reset = 1'b0;
        step(1, 32'h0000_0005, 1); chk("r.rdy", 32'(in_rdy), 32'd1);
        step(0, 32'h0, 1);         beat("r05", 8'h05, 1, 1, 1);
        step(0, 32'h0, 1);         idle_chk("r.end");

        // Counter stimulus: 3 short then 2 long words.
        pulse_reset();
`ifdef SEXT_NARROW_SERIALIZER_STATS_EN
        chk("st.rst_s", num_short, 32'd0);
        chk("st.rst_l", num_long,  32'd0);
`endif
        reset = 1'b0;
        step(1, 32'h0000_0001, 1);
        step(1, 32'h0000_0002, 1);
        step(1, 32'hFFFF_FFF3, 1);
        step(1, 32'h0000_0100, 1);
        repeat (4) step(1, 32'h8000_0000, 1);
        repeat (5) step(0, 32'h0, 1);
        idle_chk("st.end");
`ifdef SEXT_NARROW_SERIALIZER_STATS_EN
        chk("st.short", num_short, 32'd3);
        chk("st.long",  num_long,  32'd2);
        pulse_reset();
        chk("st.clr_s", num_short, 32'd0);
        chk("st.clr_l", num_long,  32'd0);
        reset = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
